// File: rtl/ksa_scheduler.sv
// RC4 key-scheduling stage. Fills the shared 256x8 S RAM with the identity
// permutation, then applies 256 key-driven swaps. Raises done once S holds
// the scheduled permutation so the decryptor can take over the RAM port.
//
// Handshake: start is a level request; only its rising edge acts, and only
// while the block is in IDLE or DONE (edges at other times are dropped).
// The key is captured on that accepted edge. done is a level that stays high
// in DONE until the next accepted start or reset. sWren is low in IDLE and
// DONE, so the RAM may be handed to the consumer while done is high.
module ksa_scheduler #(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_LENGTH = 8,
  parameter int KEY_LENGTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8*KEY_LENGTH-1:0] key,
  input  logic [RAM_WIDTH-1:0]    sOut,
  output logic [RAM_WIDTH-1:0]    sIn,
  output logic [RAM_LENGTH-1:0]   sAddr,
  output logic                    sWren,
  output logic                    done,
  output logic                    busy
);

  localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_RD_I = 3'd2,
    S_WT_I = 3'd3,
    S_WT_J = 3'd4,
    S_WR_I = 3'd5,
    S_WR_J = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t                  state_q, state_d;
  logic [RAM_LENGTH-1:0]   i_q, i_d;
  logic [RAM_LENGTH-1:0]   j_q, j_d;
  logic [RAM_WIDTH-1:0]    si_q, si_d;
  logic [RAM_WIDTH-1:0]    sj_q, sj_d;
  logic [8*KEY_LENGTH-1:0] key_q, key_d;
  logic [KW-1:0]           kidx_q, kidx_d;
  logic                    start_q, start_d;

  logic                    start_edge;
  logic                    can_start;
  logic                    i_last;
  logic [7:0]              key_byte;
  logic [RAM_LENGTH-1:0]   jn;

  assign can_start  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_edge = start & ~start_q;
  assign i_last     = &i_q;

  // Select key byte kidx; byte 0 sits in the most significant position.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_LENGTH; k++) begin
      if (kidx_q == KW'(k)) key_byte = key_q[8*(KEY_LENGTH-1-k) +: 8];
    end
  end

  // New j: 8-bit wrapping sum of old j, S[i] (arriving on sOut) and key byte.
  always_comb begin
    jn = RAM_LENGTH'(j_q + RAM_LENGTH'(sOut) + RAM_LENGTH'(key_byte));
  end

  // State and datapath registers; reset aborts any run immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
      kidx_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
      kidx_q  <= kidx_d;
      start_q <= start_d;
    end
  end

  // Next-state logic: init sweep, then a 5-cycle read/read/write/write swap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_edge) state_d = S_INIT;
      S_INIT:  if (i_last) state_d = S_RD_I;
      S_RD_I:  state_d = S_WT_I;
      S_WT_I:  state_d = S_WT_J;
      S_WT_J:  state_d = S_WR_I;
      S_WR_I:  state_d = S_WR_J;
      S_WR_J:  state_d = i_last ? S_DONE : S_RD_I;
      S_DONE:  if (start_edge) state_d = S_INIT;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: counters, captured S bytes, key latch, edge history.
  always_comb begin
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    key_d   = key_q;
    kidx_d  = kidx_q;
    start_d = start;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge && can_start) begin
          i_d    = '0;
          j_d    = '0;
          kidx_d = '0;
          key_d  = key;
        end
      end
      // i wraps from all-ones back to 0 as the sweep finishes.
      S_INIT: i_d = i_q + RAM_LENGTH'(1);
      S_WT_I: begin
        si_d = sOut;
        j_d  = jn;
      end
      S_WT_J: sj_d = sOut;
      S_WR_J: begin
        kidx_d = (kidx_q == KW'(KEY_LENGTH - 1)) ? '0 : kidx_q + KW'(1);
        if (!i_last) i_d = i_q + RAM_LENGTH'(1);
      end
      default: ;
    endcase
  end

  // Output decode from the current state; self-swaps need no special case.
  always_comb begin
    sAddr = '0;
    sIn   = '0;
    sWren = 1'b0;
    done  = 1'b0;
    busy  = 1'b1;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_INIT: begin
        sAddr = i_q;
        sIn   = RAM_WIDTH'(i_q);
        sWren = 1'b1;
      end
      S_RD_I: sAddr = i_q;
      S_WT_I: sAddr = jn;
      S_WT_J: ;
      S_WR_I: begin
        sAddr = i_q;
        sIn   = sj_q;
        sWren = 1'b1;
      end
      S_WR_J: begin
        sAddr = j_q;
        sIn   = si_q;
        sWren = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        busy = 1'b0;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ksa_scheduler.sv
// Bench for ksa_scheduler: behavioural RAM, software KSA model producing the
// expected write stream and final S contents, scenario tasks, one summary.
module tb_ksa_scheduler;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] key;
  logic [7:0]  sOut;
  logic [7:0]  sIn;
  logic [7:0]  sAddr;
  logic        sWren;
  logic        done;
  logic        busy;

  int checks;
  int errors;

  logic [7:0]  mem [0:255];
  logic [7:0]  exp_mem [0:255];
  logic [15:0] exp_q[$];
  logic [15:0] wr_q[$];

  ksa_scheduler #(.RAM_WIDTH(8), .RAM_LENGTH(8), .KEY_LENGTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .key   (key),
    .sOut  (sOut),
    .sIn   (sIn),
    .sAddr (sAddr),
    .sWren (sWren),
    .done  (done),
    .busy  (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // S RAM: synchronous write, registered read data one cycle after address.
  always @(posedge clk) begin
    if (sWren === 1'b1) mem[sAddr] <= sIn;
    sOut <= mem[sAddr];
  end

  // Write monitor: records every RAM write as {addr, data}.
  always @(negedge clk) begin
    if (sWren === 1'b1) wr_q.push_back({sAddr, sIn});
  end

  // Software RC4 KSA: expected write stream and final permutation.
  task automatic model_ksa(input logic [23:0] k);
    int s [256];
    int kb [3];
    int j;
    int t;
    kb[0] = int'(k[23:16]);
    kb[1] = int'(k[15:8]);
    kb[2] = int'(k[7:0]);
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      s[i] = i;
      exp_q.push_back({8'(i), 8'(i)});
    end
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + s[i] + kb[i % 3]) % 256;
      exp_q.push_back({8'(i), 8'(s[j])});
      exp_q.push_back({8'(j), 8'(s[i])});
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(s[i]);
  endtask

  // Full run: start edge, init-phase timing, done latency, writes, final RAM.
  // restart_at != 0 raises a second start (and a different key) while busy.
  task automatic run_ksa(input logic [23:0] k, input int restart_at, input string name);
    int cnt;
    bit got;
    int n;
    model_ksa(k);
    @(negedge clk);
    wr_q.delete();
    key   = k;
    start = 1'b1;
    cnt = 0;
    got = 0;
    while (cnt < 2000 && !got) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s start_ack: done=%b busy=%b, want done=0 busy=1", name, done, busy);
        end
      end
      if (restart_at != 0 && cnt == restart_at) begin
        start = 1'b1;
        key   = ~k;
      end
      if (restart_at != 0 && cnt == restart_at + 1) start = 1'b0;
      if (cnt <= 256) begin
        checks++;
        if (sWren !== 1'b1 || sAddr !== 8'(cnt - 1) || sIn !== 8'(cnt - 1)) begin
          errors++;
          $display("FAIL %s init_write c%0d: wren=%b addr=%0d data=%0d, want 1/%0d/%0d",
                   name, cnt, sWren, sAddr, sIn, cnt - 1, cnt - 1);
        end
      end
      if (cnt == 257) begin
        checks++;
        if (sWren !== 1'b0 || sAddr !== 8'd0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s rd_i0: wren=%b addr=%0d busy=%b, want 0/0/1", name, sWren, sAddr, busy);
        end
      end
      if (done === 1'b1) got = 1;
    end
    checks++;
    if (!got || cnt != 1537) begin
      errors++;
      $display("FAIL %s done_latency: got=%0d cycles=%0d, want 1537", name, got, cnt);
    end
    checks++;
    if (busy !== 1'b0 || sWren !== 1'b0 || sAddr !== 8'd0) begin
      errors++;
      $display("FAIL %s done_outputs: busy=%b wren=%b addr=%0d, want 0/0/0", name, busy, sWren, sAddr);
    end
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d, want %0d", name, wr_q.size(), exp_q.size());
    end
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int w = 0; w < n; w++) begin
      checks++;
      if (wr_q[w] !== exp_q[w]) begin
        errors++;
        $display("FAIL %s write[%0d]: addr=%0d data=%0d, want addr=%0d data=%0d",
                 name, w, wr_q[w][15:8], wr_q[w][7:0], exp_q[w][15:8], exp_q[w][7:0]);
      end
    end
    @(negedge clk);
    for (int a = 0; a < 256; a++) begin
      checks++;
      if (mem[a] !== exp_mem[a]) begin
        errors++;
        $display("FAIL %s S[%0d]: got %0h, want %0h", name, a, mem[a], exp_mem[a]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    key   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (sWren !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || sAddr !== 8'd0 || sIn !== 8'd0) begin
        errors++;
        $display("FAIL reset_idle c%0d: wren=%b done=%b busy=%b addr=%0d data=%0d, want all 0",
                 c, sWren, done, busy, sAddr, sIn);
      end
    end
  endtask

  // Zero key: whole run, plus the two leading self-swaps.
  task automatic test_zero_key();
    logic [15:0] want [4];
    want[0] = {8'd0, 8'd0}; want[1] = {8'd0, 8'd0};
    want[2] = {8'd1, 8'd1}; want[3] = {8'd1, 8'd1};
    run_ksa(24'h000000, 0, "zero_key");
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (wr_q.size() < 260 || wr_q[256 + w] !== want[w]) begin
        errors++;
        $display("FAIL self_swap[%0d]: got %0h, want %0h", w,
                 (wr_q.size() > 256 + w) ? wr_q[256 + w] : 16'hxxxx, want[w]);
      end
    end
  endtask

  // Key 010203: first two swaps written out by hand.
  task automatic test_first_swap();
    logic [15:0] want [4];
    want[0] = {8'd0, 8'd1}; want[1] = {8'd1, 8'd0};
    want[2] = {8'd1, 8'd3}; want[3] = {8'd3, 8'd0};
    run_ksa(24'h010203, 0, "first_swap");
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (wr_q.size() < 260 || wr_q[256 + w] !== want[w]) begin
        errors++;
        $display("FAIL first_swap_write[%0d]: got %0h, want %0h", w,
                 (wr_q.size() > 256 + w) ? wr_q[256 + w] : 16'hxxxx, want[w]);
      end
    end
  endtask

  task automatic test_random_keys();
    for (int r = 0; r < 2; r++) run_ksa(24'($urandom), 0, "random_key");
  endtask

  task automatic test_start_while_busy();
    run_ksa(24'($urandom), 600, "start_busy");
  endtask

  // Previous run left the block in DONE; a new edge must rerun from scratch.
  task automatic test_start_in_done();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_hold c%0d: done=%b busy=%b, want 1/0", c, done, busy);
      end
    end
    run_ksa(24'($urandom), 0, "start_in_done");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    key   = 24'($urandom);
    start = 1'b1;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (sWren !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sAddr !== 8'd0) begin
        errors++;
        $display("FAIL reset_mid_op c%0d: wren=%b busy=%b done=%b addr=%0d, want all 0",
                 c, sWren, busy, done, sAddr);
      end
      @(negedge clk);
    end
    run_ksa(24'($urandom), 0, "after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    key    = '0;
    test_reset();
    test_zero_key();
    test_first_swap();
    test_random_keys();
    test_start_while_busy();
    test_start_in_done();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
